decode_prefix_sequencer: RTL

- Multi-cycle, parametrised prefix scanner in the decode front end, between the instruction fetch queue and the opcode decode stage.
- Latches one fetch window, scans up to SCAN_WIDTH bytes per cycle and stops at the first non-prefix byte or when the prefix limit is hit.
- Reports group-aware prefix state (lock, rep/repne, segment, operand size, address size), bytes consumed and error causes.
- Uses valid/ready handshakes on both sides and supports flush.

---
 rtl/decode_prefix_pkg.sv | 92 +++++++++
 rtl/decode_prefix_if.sv | 42 ++++
 rtl/decode_prefix_sequencer_classify.sv | 50 +++++
 rtl/decode_prefix_sequencer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/decode_prefix_pkg.sv
// Shared types for the decode front-end prefix scanner:
// prefix byte values, group encodings and the accumulator.
package decode_prefix_pkg;

  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;
  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_FS    = 8'h64;
  localparam logic [7:0] PFX_GS    = 8'h65;
  localparam logic [7:0] PFX_OPSZ  = 8'h66;
  localparam logic [7:0] PFX_ADSZ  = 8'h67;

  typedef enum logic [2:0] {
    SEG_ES = 3'd0,
    SEG_CS = 3'd1,
    SEG_SS = 3'd2,
    SEG_DS = 3'd3,
    SEG_FS = 3'd4,
    SEG_GS = 3'd5
  } seg_e;

  typedef enum logic [1:0] {
    REP_NONE  = 2'd0,
    REP_REP   = 2'd1,
    REP_REPNE = 2'd2
  } rep_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic is_prefix;
    logic lock;
    rep_e rep_kind;
    logic operand;
    logic address;
    logic segment;
    seg_e seg_index;
  } prefix_class_t;

  typedef struct packed {
    logic lock;
    logic rep_seen;
    rep_e rep;
    logic seg_seen;
    seg_e seg;
    logic operand;
    logic address;
    logic err_repeat;
  } acc_t;

  // Fold one classified byte into the running group state.
  function automatic acc_t accumulate(
    input acc_t          a,
    input prefix_class_t c,
    input bit            err_on_rep
  );
    acc_t r;
    r = a;
    if (c.lock) begin
      if (r.lock && err_on_rep) r.err_repeat = 1'b1;
      r.lock = 1'b1;
    end
    if (c.rep_kind != REP_NONE) begin
      if (r.rep_seen && err_on_rep) r.err_repeat = 1'b1;
      else r.rep = c.rep_kind;
      r.rep_seen = 1'b1;
    end
    if (c.segment) begin
      if (r.seg_seen && err_on_rep) r.err_repeat = 1'b1;
      else r.seg = c.seg_index;
      r.seg_seen = 1'b1;
    end
    if (c.operand) begin
      if (r.operand && err_on_rep) r.err_repeat = 1'b1;
      r.operand = 1'b1;
    end
    if (c.address) begin
      if (r.address && err_on_rep) r.err_repeat = 1'b1;
      r.address = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_prefix_if.sv
// Handshake and result bundle between fetch queue,
// prefix scanner and opcode decode.
interface decode_prefix_if #(
  parameter int FETCH_BYTES = 16,
  parameter int MAX_PREFIX  = 4
) ();
  localparam int CW = $clog2(MAX_PREFIX + 1);

  logic                     i_flush;
  logic [8*FETCH_BYTES-1:0] i_instruction;
  logic                     i_valid;
  logic                     o_ready;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_bus_lock;
  logic [1:0]               o_repeat;
  logic                     o_operand_size;
  logic                     o_address_size;
  logic                     o_segment_override;
  logic [2:0]               o_segment_override_index;
  logic [CW-1:0]            o_consumed_instruction_bytes;
  logic                     o_error_repeat;
  logic                     o_error_too_many;

  modport slave (
    input  i_flush, i_instruction, i_valid, i_ready,
    output o_ready, o_valid, o_bus_lock, o_repeat,
    output o_operand_size, o_address_size,
    output o_segment_override, o_segment_override_index,
    output o_consumed_instruction_bytes,
    output o_error_repeat, o_error_too_many
  );

  modport master (
    output i_flush, i_instruction, i_valid, i_ready,
    input  o_ready, o_valid, o_bus_lock, o_repeat,
    input  o_operand_size, o_address_size,
    input  o_segment_override, o_segment_override_index,
    input  o_consumed_instruction_bytes,
    input  o_error_repeat, o_error_too_many
  );
endinterface

// File: rtl/decode_prefix_sequencer_classify.sv
// Single-byte prefix classifier; one copy per scan lane.
// Non-prefix bytes produce an all-zero class.
module prefix_byte_classify
  import decode_prefix_pkg::*;
(
  input  logic [7:0]    data,
  output prefix_class_t cls
);

  // Decode the byte into its prefix group and value.
  always_comb begin
    cls = '0;
    unique case (1'b1)
      data == PFX_LOCK:  cls.lock = 1'b1;
      data == PFX_REPNE: cls.rep_kind = REP_REPNE;
      data == PFX_REP:   cls.rep_kind = REP_REP;
      data == PFX_OPSZ:  cls.operand = 1'b1;
      data == PFX_ADSZ:  cls.address = 1'b1;
      data == PFX_ES: begin
        cls.segment   = 1'b1;
        cls.seg_index = SEG_ES;
      end
      data == PFX_CS: begin
        cls.segment   = 1'b1;
        cls.seg_index = SEG_CS;
      end
      data == PFX_SS: begin
        cls.segment   = 1'b1;
        cls.seg_index = SEG_SS;
      end
      data == PFX_DS: begin
        cls.segment   = 1'b1;
        cls.seg_index = SEG_DS;
      end
      data == PFX_FS: begin
        cls.segment   = 1'b1;
        cls.seg_index = SEG_FS;
      end
      data == PFX_GS: begin
        cls.segment   = 1'b1;
        cls.seg_index = SEG_GS;
      end
      default: ;
    endcase
    cls.is_prefix = cls.lock | cls.operand
                  | cls.address | cls.segment
                  | (cls.rep_kind != REP_NONE);
  end

endmodule

// File: rtl/decode_prefix_sequencer.sv
// Multi-cycle prefix scanner: latches a fetch window and
// walks SCAN_WIDTH bytes per cycle up to MAX_PREFIX.
module decode_prefix_sequencer
  import decode_prefix_pkg::*;
#(
  parameter int FETCH_BYTES     = 16,
  parameter int MAX_PREFIX      = 4,
  parameter int SCAN_WIDTH      = 1,
  parameter int ERROR_ON_REPEAT = 1
) (
  input logic            clock,
  input logic            reset,
  decode_prefix_if.slave bus
);

  localparam int CW = $clog2(MAX_PREFIX + 1);
  localparam int WB = 8 * (MAX_PREFIX + 1);

  state_e        state;
  logic [WB-1:0] window;
  logic [CW-1:0] ptr;
  acc_t          acc_q;
  acc_t          acc_n;
  acc_t          res_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic          tm_q;
  logic          tm_n;
  logic          stop;
  logic          valid_q;
  logic          ready_q;
  prefix_class_t cls [SCAN_WIDTH];
  logic          unused_bits;

  for (genvar g = 0; g < SCAN_WIDTH; g++) begin : g_lane
    logic [7:0] lane_byte;

    // Pick this lane's byte; lanes past the limit clip.
    always_comb begin
      int idx;
      idx = int'(ptr) + g;
      if (idx > MAX_PREFIX) idx = MAX_PREFIX;
      lane_byte = window[8*idx +: 8];
    end

    prefix_byte_classify u_cls (
      .data (lane_byte),
      .cls  (cls[g])
    );
  end

  // Walk the lanes in byte order, stopping at the first
  // non-prefix byte or at a prefix sitting on the limit.
  always_comb begin
    int idx;
    acc_n = acc_q;
    cnt_n = '0;
    tm_n  = 1'b0;
    stop  = 1'b0;
    idx   = 0;
    for (int j = 0; j < SCAN_WIDTH; j++) begin
      if (!stop) begin
        idx = int'(ptr) + j;
        if (!cls[j].is_prefix) begin
          stop  = 1'b1;
          cnt_n = CW'(idx);
        end else if (idx >= MAX_PREFIX) begin
          stop  = 1'b1;
          tm_n  = 1'b1;
          cnt_n = CW'(MAX_PREFIX);
        end else begin
          acc_n = accumulate(acc_n, cls[j],
                             ERROR_ON_REPEAT != 0);
        end
      end
    end
  end

  // Sequencer FSM with registered result fields.
  always_ff @(posedge clock) begin
    if (reset || bus.i_flush) begin
      state   <= S_IDLE;
      window  <= '0;
      ptr     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tm_q    <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.i_valid) begin
            window  <= bus.i_instruction[WB-1:0];
            acc_q   <= '0;
            ptr     <= '0;
            ready_q <= 1'b0;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          acc_q <= acc_n;
          if (stop) begin
            res_q   <= acc_n;
            cnt_q   <= cnt_n;
            tm_q    <= tm_n;
            valid_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            ptr <= ptr + CW'(SCAN_WIDTH);
          end
        end
        S_DONE: begin
          if (bus.i_ready) begin
            res_q   <= '0;
            cnt_q   <= '0;
            tm_q    <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_bus_lock = res_q.lock;
  assign bus.o_repeat = res_q.rep;
  assign bus.o_operand_size = res_q.operand;
  assign bus.o_address_size = res_q.address;
  assign bus.o_segment_override = res_q.seg_seen;
  assign bus.o_segment_override_index = res_q.seg;
  assign bus.o_consumed_instruction_bytes = cnt_q;
  assign bus.o_error_repeat = res_q.err_repeat;
  assign bus.o_error_too_many = tm_q;

  assign unused_bits =
    ^{bus.i_instruction[8*FETCH_BYTES-1:WB],
      res_q.rep_seen};

endmodule
